// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state/owner types and counter widths for the memory arbiter.
package unified_mem_arbiter_pkg;
    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
    localparam int LAT_CNT_W = 4;
    localparam int STARVE_W  = 4;
endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory between fetch and data ports,
// data priority with a fetch starvation bound, and redirect kill of an in-flight fetch.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    arb_state_t state, state_nx;
    arb_owner_t owner;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [STARVE_W-1:0]  starve_cnt;
    logic                 killed, pick_if, issue, fin;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;

    always_comb begin
        pick_if   = if_req & (~d_req | (starve_cnt == STARVE_W'(STARVE_LIMIT)));
        issue     = (state == ARB_IDLE) & ~reset & (if_req | d_req);
        fin       = (state == ARB_WAIT) & (lat_cnt == '0);
        state_nx  = issue ? ARB_WAIT : fin ? ARB_IDLE : state;
        mem_en    = issue;
        mem_we    = issue & ~pick_if & d_we;
        // Outside the issue cycle the bus holds the last winner so it stays deterministic.
        mem_addr  = issue ? (pick_if ? if_addr : d_addr) : addr_q;
        mem_wdata = issue ? (pick_if ? '0 : d_wdata) : wdata_q;
        if_done   = fin & (owner == OWN_IF) & ~killed & ~if_kill;
        d_done    = fin & (owner == OWN_D);
        if_rdata  = if_done ? mem_rdata : '0;
        d_rdata   = d_done ? mem_rdata : '0;
        if_stall  = if_req & ~if_done;
        d_stall   = d_req & ~d_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            killed     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                owner   <= pick_if ? OWN_IF : OWN_D;
                lat_cnt <= LAT_CNT_W'(MEM_LATENCY - 1);
                killed  <= 1'b0;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end else if (state == ARB_WAIT) begin
                lat_cnt <= fin ? lat_cnt : lat_cnt - 1'b1;
                if (owner == OWN_IF && if_kill)
                    killed <= 1'b1;
            end
            // Counts data wins that bypassed a waiting fetch; saturates at the limit.
            starve_cnt <= (~if_req | (issue & pick_if)) ? '0 :
                          (issue && starve_cnt != STARVE_W'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenarios plus a randomized run checked against a
// cycle-slot reference model of the arbitration rules.
module tb_unified_mem_arbiter;
    logic        clk, reset;
    logic        if_req, if_kill, if_done, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_done, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word = addr ^ A5A5A5A5 unless written, valid two cycles after issue.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] p0, p1;
    assign mem_rdata = p1;
    always @(posedge clk) begin
        if (mem_en) begin
            p0 <= mem.exists(mem_addr) ? mem[mem_addr] : mem_addr ^ 32'hA5A5A5A5;
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
        p1 <= p0;
    end

    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a ^ 32'hA5A5A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive point is posedge+1, check point posedge+2.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue;
        int n = 0;
        while (mem_en !== 1'b1 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("issue_timeout", mem_en, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; if_req = 0; if_addr = 0; if_kill = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        tick; tick; #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // Single fetch: issue at t, done at t+2, next issue at t+3.
        tick; reset = 0; if_req = 1; if_addr = 32'h40; #1;
        chk("f1_en", mem_en, 1);
        chk("f1_addr", mem_addr, 32'h40);
        chk("f1_we", mem_we, 0);
        chk("f1_stall", if_stall, 1);
        tick; #1;
        chk("f1_en_t1", mem_en, 0);
        chk("f1_done_t1", if_done, 0);
        tick; #1;
        chk("f1_done", if_done, 1);
        chk("f1_rdata", if_rdata, 32'hA5A5A5E5);
        chk("f1_stall_done", if_stall, 0);
        chk("f1_en_t2", mem_en, 0);
        tick; if_addr = 32'h44; #1;
        chk("f2_reissue", mem_en, 1);
        tick; tick; if_req = 0; tick;

        // Simultaneous requests: data first, then fetch.
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100; #1;
        chk("both_addr", mem_addr, 32'h100);
        tick; tick; #1;
        chk("both_d_done", d_done, 1);
        chk("both_d_rdata", d_rdata, 32'hA5A5A4A5);
        chk("both_if_wait", if_done, 0);
        tick; d_req = 0; #1;
        chk("both_f_issue", mem_en, 1);
        chk("both_f_addr", mem_addr, 32'h40);
        tick; tick; #1;
        chk("both_if_done", if_done, 1);
        chk("both_if_rdata", if_rdata, 32'hA5A5A5E5);
        tick; if_req = 0;

        // Store then load of the same address.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; #1;
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        tick; tick; #1;
        chk("st_done", d_done, 1);
        tick; d_we = 0; #1;
        chk("ld_en", mem_en, 1);
        chk("ld_we", mem_we, 0);
        tick; tick; #1;
        chk("ld_done", d_done, 1);
        chk("ld_rdata", d_rdata, 32'hDEADBEEF);
        tick; d_req = 0;

        // Starvation bound: four data grants then one fetch grant, repeating.
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300; #1;
        for (int g = 0; g < 10; g++) begin
            wait_issue;
            chk("starve_grant", mem_addr == 32'h80, (g % 5) == 4);
            tick; tick;
            if (mem_addr != 32'h80) d_addr = d_addr + 4;
            #1;
            chk("starve_done", (g % 5) == 4 ? if_done : d_done, 1);
        end
        if_req = 0; d_req = 0;
        tick; tick;

        // Kill an in-flight fetch; a redirected fetch then issues at t+3.
        if_req = 1; if_addr = 32'h40; #1;
        chk("kill_issue", mem_en, 1);
        tick; if_kill = 1; #1;
        tick; if_kill = 0; #1;
        chk("kill_no_done", if_done, 0);
        chk("kill_rdata", if_rdata, 0);
        if_addr = 32'h80;
        tick; #1;
        chk("redir_issue", mem_en, 1);
        chk("redir_addr", mem_addr, 32'h80);
        tick; tick; #1;
        chk("redir_done", if_done, 1);
        chk("redir_rdata", if_rdata, 32'hA5A5A525);
        tick; if_req = 0;

        // Reset mid-access drops the result; the held d_req reissues afterwards.
        d_req = 1; d_we = 0; d_addr = 32'h100; #1;
        chk("rstm_issue", mem_en, 1);
        tick; reset = 1;
        tick; #1;
        chk("rstm_d_done", d_done, 0);
        chk("rstm_mem_en", mem_en, 0);
        chk("rstm_mem_addr", mem_addr, 0);
        chk("rstm_d_rdata", d_rdata, 0);
        chk("rstm_d_stall", d_stall, 1);
        tick; reset = 0; #1;
        chk("rstm_reissue", mem_en, 1);
        chk("rstm_readdr", mem_addr, 32'h100);
        tick; tick; #1;
        chk("rstm_done", d_done, 1);
        chk("rstm_rdata", d_rdata, 32'hA5A5A4A5);
        tick; d_req = 0;
        tick;

        // Randomized traffic against a slot-level reference model.
        begin
            int free_at = 0, issue_k = -100, streak = 0;
            bit own_if = 0, killed_m = 0, is_load = 0, clr_if = 0, clr_d = 0;
            bit exp_en, win_if, done_now, exp_if_done, exp_d_done;
            logic [31:0] exp_data = 0;
            for (int k = 0; k < 400; k++) begin
                if (k > 0) tick;
                if (clr_if) if_req = 0;
                if (clr_d) d_req = 0;
                clr_if = 0; clr_d = 0;
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1;
                    if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                end
                if (!d_req && $urandom_range(0, 1) == 0) begin
                    d_req = 1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    d_wdata = $urandom;
                end
                if_kill = ($urandom_range(0, 5) == 0);
                #1;
                exp_en = (k >= free_at) && (if_req || d_req);
                chk("rnd_en", mem_en, exp_en);
                if (exp_en) begin
                    win_if = if_req && (!d_req || streak == 4);
                    chk("rnd_addr", mem_addr, win_if ? if_addr : d_addr);
                    chk("rnd_we", mem_we, win_if ? 1'b0 : d_we);
                    if (!win_if && d_we) chk("rnd_wdata", mem_wdata, d_wdata);
                    own_if = win_if; issue_k = k; free_at = k + 3; killed_m = 0;
                    is_load = win_if || !d_we;
                    exp_data = ref_rd(win_if ? if_addr : d_addr);
                    if (!win_if && d_we) ref_mem[d_addr] = d_wdata;
                    if (win_if) streak = 0;
                    else if (if_req && streak < 4) streak++;
                end
                if (!if_req) streak = 0;
                if (own_if && k > issue_k && k <= issue_k + 2 && if_kill) killed_m = 1;
                done_now = (k == issue_k + 2);
                exp_if_done = done_now && own_if && !killed_m;
                exp_d_done = done_now && !own_if;
                chk("rnd_if_done", if_done, exp_if_done);
                chk("rnd_d_done", d_done, exp_d_done);
                chk("rnd_if_rdata", if_rdata, exp_if_done ? exp_data : 32'h0);
                if (!exp_d_done || is_load) chk("rnd_d_rdata", d_rdata, exp_d_done ? exp_data : 32'h0);
                chk("rnd_if_stall", if_stall, if_req && !exp_if_done);
                if (done_now) begin
                    if (own_if) clr_if = 1;
                    else clr_d = 1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
